// File: rtl/cache_types_pkg.sv
// Shared cache typedefs and the tree-PLRU node-update helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
//
// Contents:
//   PLRU_MAX_WAYS  largest associativity the PLRU helpers are sized for
//   way_idx_t      way index used by the dcache FSM
//   set_idx_t      set index used by the dcache FSM
//   plru_bits_t    node-bit vector sized for PLRU_MAX_WAYS
//   plru_update()  node bits + accessed way -> node bits with that way made MRU
package cache_types_pkg;

    localparam int PLRU_MAX_WAYS = 16;
    localparam int DC_WAYS       = 8;
    localparam int DC_SETS       = 16;

    typedef logic [$clog2(DC_WAYS)-1:0] way_idx_t;
    typedef logic [$clog2(DC_SETS)-1:0] set_idx_t;
    typedef logic [PLRU_MAX_WAYS-2:0]   plru_bits_t;

    // Walks the root-to-leaf path of 'way' in heap order and points each
    // node on it at the opposite side, so the way just used is not chosen
    // next. way_w is the number of tree levels (log2 of the associativity).
    function automatic plru_bits_t plru_update(input plru_bits_t bits,
                                               input logic [3:0] way,
                                               input int         way_w);
        plru_bits_t r;
        int         node;
        logic       b;
        r    = bits;
        node = 0;
        for (int l = 0; l < way_w; l++) begin
            b       = way[way_w-1-l];
            r[node] = ~b;
            node    = 2*node + 1 + int'(b);
        end
        return r;
    endfunction

endpackage

// File: rtl/plru_set_ctrl_if.sv
// Lookup/access/victim signal bundle between the cache FSM and plru_set_ctrl.
// Latency: none (wires only).
// Backpressure: none; one lookup and one access may be presented every cycle.
//
// master = cache FSM (drives lookup/access, receives victim)
// slave  = plru_set_ctrl
interface plru_set_ctrl_if #(
    parameter int WAYS = 8,
    parameter int SETS = 16
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    logic             lookup_valid_i;
    logic [SET_W-1:0] lookup_set_i;
    logic [WAYS-1:0]  valid_mask_i;
    logic [WAYS-1:0]  lock_mask_i;
    logic             access_valid_i;
    logic [SET_W-1:0] access_set_i;
    logic [WAY_W-1:0] access_way_i;
    logic             victim_valid_o;
    logic [WAY_W-1:0] victim_way_o;
    logic             victim_none_o;

    modport master (
        output lookup_valid_i, lookup_set_i, valid_mask_i, lock_mask_i,
        output access_valid_i, access_set_i, access_way_i,
        input  victim_valid_o, victim_way_o, victim_none_o
    );

    modport slave (
        input  lookup_valid_i, lookup_set_i, valid_mask_i, lock_mask_i,
        input  access_valid_i, access_set_i, access_way_i,
        output victim_valid_o, victim_way_o, victim_none_o
    );

endinterface

// File: rtl/plru_victim_walk.sv
// Combinational victim chooser: invalid-first, then PLRU walk steering around locked subtrees.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   i_bits   node bits of one set, heap order (node n -> children 2n+1 / 2n+2)
//   i_valid  valid bit per way
//   i_lock   1 = way may not be chosen
//   o_way    chosen victim way (0 when o_none)
//   o_none   every way locked
module plru_victim_walk #(
    parameter  int WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  i_bits,
    input  logic [WAYS-1:0]  i_valid,
    input  logic [WAYS-1:0]  i_lock,
    output logic [WAY_W-1:0] o_way,
    output logic             o_none
);

    always_comb begin : p_walk
        // w_avail is the full heap: entries 0..WAYS-2 are internal nodes,
        // WAYS-1..2*WAYS-2 are the leaves (ways 0..WAYS-1). A set bit means
        // the subtree below still contains at least one unlocked way.
        logic [2*WAYS-2:0] w_avail;
        logic              w_found;
        logic              w_b;
        int                w_node;

        o_way   = '0;
        o_none  = 1'b0;
        w_avail = '0;
        w_found = 1'b0;
        w_b     = 1'b0;
        w_node  = 0;

        for (int w = 0; w < WAYS; w++) begin
            w_avail[WAYS-1+w] = ~i_lock[w];
        end
        for (int n = WAYS-2; n >= 0; n--) begin
            w_avail[n] = w_avail[2*n+1] | w_avail[2*n+2];
        end

        // Descending scan so the lowest eligible invalid way wins.
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!i_valid[w] && !i_lock[w]) begin
                o_way   = WAY_W'(w);
                w_found = 1'b1;
            end
        end

        if (!w_avail[0]) begin
            o_none = 1'b1;
            o_way  = '0;
        end else if (!w_found) begin
            // Follow the node bit unless that side is entirely locked; the
            // root check above guarantees the other side then has a way.
            for (int l = 0; l < WAY_W; l++) begin
                w_b = i_bits[w_node];
                if (!w_avail[2*w_node + 1 + int'(w_b)]) begin
                    w_b = ~w_b;
                end
                w_node = 2*w_node + 1 + int'(w_b);
            end
            o_way = WAY_W'(w_node - (WAYS-1));
        end
    end

endmodule

// File: rtl/plru_set_ctrl.sv
// Per-set tree-PLRU state with MRU update on hit/fill and a registered victim lookup.
// Latency: victim 1 cycle after lookup_valid_i; access updates take effect at the next edge.
// Backpressure: none; accepts one lookup and one access every cycle, never stalls.
//
// Ports:
//   clk  clock (rising edge)
//   rst  asynchronous active-low reset
//   bus  plru_set_ctrl_if.slave: lookup_* / valid/lock masks in, access_* in,
//        victim_valid_o / victim_way_o / victim_none_o out
module plru_set_ctrl
    import cache_types_pkg::*;
#(
    parameter  int WAYS  = 8,
    parameter  int SETS  = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic         clk,
    input  logic         rst,
    plru_set_ctrl_if.slave bus
);

    logic [WAYS-2:0]  r_bits [SETS];
    logic             r_vld;
    logic [WAY_W-1:0] r_way;
    logic             r_none;

    logic [WAY_W-1:0] w_node [WAY_W];
    logic             w_pbit [WAY_W];
    logic [WAYS-2:0]  w_upd_bits;
    logic [WAYS-2:0]  w_lkp_bits;
    logic             w_fwd;
    logic [WAY_W-1:0] w_way;
    logic             w_none;

    // Node touched at level l: first heap index of that level plus the
    // upper l bits of the accessed way.
    for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
        assign w_pbit[l] = bus.access_way_i[WAY_W-1-l];
        if (l == 0) begin : g_root
            assign w_node[l] = '0;
        end else begin : g_inner
            assign w_node[l] = WAY_W'((1 << l) - 1) + (bus.access_way_i >> (WAY_W-l));
        end
    end

    always_comb begin
        w_upd_bits = r_bits[bus.access_set_i];
        for (int l = 0; l < WAY_W; l++) begin
            w_upd_bits[w_node[l]] = ~w_pbit[l];
        end
    end

    // A same-cycle access to the looked-up set is folded in first so the
    // way just touched is steered away from.
    assign w_fwd      = bus.access_valid_i && (bus.access_set_i == bus.lookup_set_i);
    assign w_lkp_bits = w_fwd ? w_upd_bits : r_bits[bus.lookup_set_i];

    plru_victim_walk #(.WAYS(WAYS)) u_walk (
        .i_bits  (w_lkp_bits),
        .i_valid (bus.valid_mask_i),
        .i_lock  (bus.lock_mask_i),
        .o_way   (w_way),
        .o_none  (w_none)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_bits[s] <= '0;
            end
            r_vld  <= 1'b0;
            r_way  <= '0;
            r_none <= 1'b0;
        end else begin
            if (bus.access_valid_i) begin
                r_bits[bus.access_set_i] <= w_upd_bits;
            end
            r_vld <= bus.lookup_valid_i;
            if (bus.lookup_valid_i) begin
                r_way  <= w_way;
                r_none <= w_none;
            end
        end
    end

    assign bus.victim_valid_o = r_vld;
    assign bus.victim_way_o   = r_way;
    assign bus.victim_none_o  = r_none;

endmodule

// File: tb/tb_plru_set_ctrl.sv
// Directed bench for plru_set_ctrl (WAYS=4, SETS=4) with a queued scoreboard.
// Latency expected: victim on the cycle after each lookup.
// Backpressure: none exercised (design never stalls).
module tb_plru_set_ctrl;

    logic clk;
    logic rst;

    plru_set_ctrl_if #(.WAYS(4), .SETS(4)) bus ();

    plru_set_ctrl #(.WAYS(4), .SETS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] way;
        logic       none;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // Monitor: on every falling edge either a response is due (compare it)
    // or the valid pulse must be absent.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            e_mon = q.pop_front();
            total++;
            if (!(bus.victim_valid_o === 1'b1 && bus.victim_way_o === e_mon.way &&
                  bus.victim_none_o === e_mon.none)) begin
                bad++;
                $display("FAIL victim cyc=%0d got vld=%b way=%0d none=%b want vld=1 way=%0d none=%b",
                         cyc, bus.victim_valid_o, bus.victim_way_o, bus.victim_none_o,
                         e_mon.way, e_mon.none);
            end
        end else begin
            total++;
            if (bus.victim_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_valid cyc=%0d got vld=%b want vld=0", cyc, bus.victim_valid_o);
            end
        end
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit lv, input int ls, input logic [3:0] vm, input logic [3:0] lm,
                         input bit av, input int as_, input int aw);
        bus.lookup_valid_i = lv;
        bus.lookup_set_i   = 2'(ls);
        bus.valid_mask_i   = vm;
        bus.lock_mask_i    = lm;
        bus.access_valid_i = av;
        bus.access_set_i   = 2'(as_);
        bus.access_way_i   = 2'(aw);
    endtask

    // One cycle of stimulus; a lookup queues its expected victim for the
    // falling edge after the capturing rising edge.
    task automatic op(input bit lv, input int ls, input logic [3:0] vm, input logic [3:0] lm,
                      input bit av, input int as_, input int aw,
                      input int ew, input bit en);
        @(posedge clk); #1;
        drive(lv, ls, vm, lm, av, as_, aw);
        if (lv) q.push_back('{way: 2'(ew), none: en, due: cyc + 1});
    endtask

    task automatic idle();
        op(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 4'h0, 4'h0, 0, 0, 0);
        #2;
        chk("reset_valid", int'(bus.victim_valid_o), 0);
        chk("reset_way",   int'(bus.victim_way_o),   0);
        chk("reset_none",  int'(bus.victim_none_o),  0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        // lv ls vm      lm      av as aw  ew en
        op(1, 0, 4'hF,   4'h0,   0, 0, 0,  0, 0);  // fresh set: all bits 0
        op(0, 0, 4'h0,   4'h0,   1, 0, 0,  0, 0);  // access s0 w0 -> 011
        op(1, 0, 4'hF,   4'h0,   0, 0, 0,  2, 0);
        op(0, 0, 4'h0,   4'h0,   1, 0, 2,  0, 0);  // access s0 w2 -> 110
        op(1, 0, 4'hF,   4'h0,   0, 0, 0,  1, 0);
        op(1, 0, 4'b1011,4'h0,   0, 0, 0,  2, 0);  // invalid way wins
        op(1, 0, 4'b0011,4'b0100,0, 0, 0,  3, 0);  // invalid but locked skipped
        op(1, 3, 4'hF,   4'b0011,0, 0, 0,  2, 0);  // left subtree locked
        op(1, 3, 4'hF,   4'hF,   0, 0, 0,  0, 1);  // all locked
        op(1, 1, 4'hF,   4'h0,   1, 1, 0,  2, 0);  // forwarded same-set access
        op(1, 3, 4'hF,   4'h0,   1, 2, 0,  0, 0);  // access other set: no effect
        op(1, 2, 4'hF,   4'h0,   1, 2, 0,  2, 0);  // repeated access idempotent
        op(1, 1, 4'hF,   4'b0011,1, 1, 2,  3, 0);  // forwarded + lock steering
        op(1, 1, 4'hF,   4'b0111,1, 1, 3,  3, 0);  // accessed way is the only one left
        idle();
        op(1, 3, 4'b1110,4'b0001,0, 0, 0,  1, 0);  // locked invalid -> PLRU around lock
        op(1, 3, 4'b0000,4'b0001,0, 0, 0,  1, 0);  // lowest unlocked invalid
        op(1, 0, 4'hF,   4'h0,   0, 0, 0,  1, 0);  // lookups left s0 unchanged
        op(0, 0, 4'h0,   4'h0,   1, 0, 1,  0, 0);  // access s0 w1 -> 101
        op(1, 0, 4'hF,   4'h0,   0, 0, 0,  3, 0);
        idle();
        idle();

        // Lookup, then reset while its result is on the outputs.
        @(posedge clk); #1;
        drive(1, 0, 4'hF, 4'h0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 4'h0, 4'h0, 0, 0, 0);
        chk("pre_rst_valid", int'(bus.victim_valid_o), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(bus.victim_valid_o), 0);
        chk("mid_rst_way",   int'(bus.victim_way_o),   0);
        chk("mid_rst_none",  int'(bus.victim_none_o),  0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle();

        op(1, 0, 4'hF,   4'h0,   0, 0, 0,  0, 0);  // bits cleared by reset
        op(1, 1, 4'hF,   4'h0,   0, 0, 0,  0, 0);
        op(1, 2, 4'hF,   4'h0,   0, 0, 0,  0, 0);
        idle();
        idle();
        idle();

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
